uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Serial-to-byte receiver for the 8N1 UART line (`UART_RX_i`) at the front of the SRAM demo `top`. It recovers bytes from the line and hands them to the SRAM command logic over a valid/ready handshake. It flags framing errors and overruns. Defaults target the 12 MHz board clock at 115 200 baud.

## Interface
- `CLK_FREQ`, 12_000_000: input clock frequency in Hz.
- `BAUD`, 115_200: line rate in bit/s.
- `DIVISOR`, `CLK_FREQ/BAUD` (104): clocks per bit, integer division, must be ≥ 8.
- `HALF`, `DIVISOR/2` (52): clocks from start edge to start-bit centre.

Ports:
- `CLK_IN`  in  1  single system clock, all logic on rising edge.
- `RST_IN`  in  1  synchronous, active-high reset.
- `UART_RX_i`  in  1  asynchronous serial line, idle high.
- `DATA_o`  out  8  received byte, stable while `VALID_o`.
- `VALID_o`  out  1  byte available in holding register.
- `READY_i`  in  1  consumer accepts byte when `VALID_o & READY_i`.
- `FRAME_ERR_o`  out  1  one-cycle pulse: stop bit sampled low.
- `OVERRUN_o`  out  1  one-cycle pulse: byte dropped because holding register was full.
- `BUSY_o`  out  1  high in any state other than IDLE.

## Operation
- **Synchronizer**
  - `UART_RX_i` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`.
  - No other logic samples the raw pin.
- **Bit timing**
  - A down-counter `cnt` (width `$clog2(DIVISOR)`) produces a sample strobe when `cnt==0`.
  - The counter reloads on every strobe.
- **FSM states** (transition conditions):
  - IDLE: if `rx_s==0`, load `cnt=HALF-1` and go to START.
  - START: on strobe, if `rx_s==1` it is a false start, so go to IDLE with no flags. Otherwise load `cnt=DIVISOR-1`, clear `bit_idx`, and go to DATA.
  - DATA: on strobe, shift `rx_s` into `shreg` LSB-first and reload `DIVISOR-1`. After `bit_idx==7`, go to STOP.
  - STOP: on strobe, if `rx_s==1`, deliver `shreg` and go to IDLE. If `rx_s==0`, pulse `FRAME_ERR_o`, drop the byte, and go to BREAK.
  - BREAK: wait until `rx_s==1`, then go to IDLE. This prevents a held-low line from re-triggering.
- **Delivery rules**
  - If the holding register is empty, or is consumed in the same cycle (`VALID_o & READY_i`), load `DATA_o` and set `VALID_o`.
  - If it is full and not consumed that cycle, keep the old byte, drop the new one, and pulse `OVERRUN_o`.
  - `VALID_o` clears on `VALID_o & READY_i` when no delivery happens in that cycle.
- **Handshake**
  - `DATA_o` and `VALID_o` change only on a handshake or a delivery.
  - `VALID_o` never drops without `READY_i`.
- **Reset**
  - Reset is allowed at any time, including mid-byte.
  - Reset values: state IDLE, `cnt=0`, `shreg=0`, `DATA_o=8'h00`, `VALID_o=0`, `FRAME_ERR_o=0`, `OVERRUN_o=0`, `BUSY_o=0`, synchronizer flops =1.
  - A partially received byte is discarded. Reception resumes on the next falling edge seen after reset.

## Timing
- **Start-edge latency**: `rx_s` falls 2 cycles after the pin falls (±1 for metastability alignment).
- **Sample points**:
  - Start-bit centre: `HALF` cycles after `rx_s` falls.
  - Data bit n: `HALF + (n+1)*DIVISOR` cycles after `rx_s` falls.
  - Stop bit: `HALF + 9*DIVISOR` cycles after `rx_s` falls.
- **Byte latency**: `VALID_o` rises 1 cycle after the stop sample, i.e. 2+52+936+1 = 991 cycles after the pin's start edge at defaults.
- **Pulse outputs**: `FRAME_ERR_o` and `OVERRUN_o` are registered and high for exactly one cycle, in the same cycle delivery would have occurred.
- **Back-to-back frames**: STOP returns to IDLE immediately, so the next start edge can be recognised one cycle after the stop sample. This tolerates a sender up to ~½ bit fast.
- **Acceptance**: the consumer may accept in the first cycle `VALID_o` is high; zero-wait handshake.

## Structure
- **Shared package `uart_pkg`** holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK);
  - `DEFAULT_CLK_FREQ`;
  - `DEFAULT_BAUD`;
  - a `calc_divisor` function, for reuse by the future UART transmitter.
- **Sub-module `sync_2ff`**: generic 2-flop synchronizer with a reset value parameter, instantiated once for `UART_RX_i`.
- **Top-level body**: everything else (FSM, counter, shift register, holding register) stays in `uart_byte_rx`.

## Test plan
Bench: 83 ns clock, bit period = `DIVISOR` clocks.
- **Single byte**: send 0xAA with `READY_i=1` → `DATA_o=0xAA`, one-cycle `VALID_o` at 991±1 cycles after the start edge, no flags.
- **Overrun**: hold `READY_i=0`, send 0x3C then 0x55 → `DATA_o` stays 0x3C with `VALID_o` high; `OVERRUN_o` pulses once at the 0x55 stop sample. Raising `READY_i` then drops `VALID_o` after one cycle.
- **False start**: drive a 20-cycle low glitch on an idle line → FSM returns to IDLE at the start-bit sample; no `VALID_o`, no `FRAME_ERR_o`, `BUSY_o` high for ~54 cycles.
- **Framing error / break**: send 0x0F with the stop bit low, then hold the line low 3000 cycles → one `FRAME_ERR_o` pulse, no `VALID_o`, FSM stays in BREAK. A following 0x81 is received correctly after the line returns high.
- **Reset mid-byte**: assert `RST_IN` for 1 cycle during data bit 4 of 0xC3 → all outputs at reset values next cycle, no `VALID_o` for that byte. A subsequent 0x5A is received correctly.
- **Back-to-back stream**: send 0x00, 0xFF, 0xA5 back-to-back (stop bit immediately followed by start) with `READY_i=1` → three `VALID_o` pulses in order with those values, spaced 10×`DIVISOR` cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, board defaults and baud divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   localparam int DEFAULT_CLK_FREQ = 12_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   // Clocks per bit, truncating; shared with the transmitter so both ends agree.
   function automatic int calc_divisor(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: centre-samples each bit and hands bytes out through a one-deep
// holding register with valid/ready, flagging framing errors and overruns.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for rx_s to fall
//   ST_START | counting to the start-bit centre to reject glitches
//   ST_DATA  | sampling 8 data bits LSB-first, one per bit period
//   ST_STOP  | sampling the stop bit, then deliver or flag framing error
//   ST_BREAK | stop bit was low; wait for the line to return high
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int BAUD     = DEFAULT_BAUD,
   parameter int DIVISOR  = calc_divisor(CLK_FREQ, BAUD),
   parameter int HALF     = DIVISOR / 2
) (
   input  logic       CLK_IN,
   input  logic       RST_IN,
   input  logic       UART_RX_i,
   output logic [7:0] DATA_o,
   output logic       VALID_o,
   input  logic       READY_i,
   output logic       FRAME_ERR_o,
   output logic       OVERRUN_o,
   output logic       BUSY_o
);

   localparam int             CW          = $clog2(DIVISOR);
   localparam logic [CW-1:0]  RELOAD_FULL = CW'(DIVISOR - 1);
   localparam logic [CW-1:0]  RELOAD_HALF = CW'(HALF - 1);

   if (DIVISOR < 8) begin : g_bad_divisor
      $error("uart_byte_rx: DIVISOR must be at least 8");
   end

   logic            rx_s;

   rx_state_e       state_q,     state_d;
   logic [CW-1:0]   cnt_q,       cnt_d;
   logic [2:0]      bit_idx_q,   bit_idx_d;
   logic [7:0]      shreg_q,     shreg_d;
   logic [7:0]      data_q,      data_d;
   logic            valid_q,     valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q,   overrun_d;
   logic            busy_q,      busy_d;

   logic            strobe;
   logic            take;
   logic            deliver;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk (CLK_IN),
      .rst (RST_IN),
      .d   (UART_RX_i),
      .q   (rx_s)
   );

   always_comb begin
      strobe      = (cnt_q == '0);
      take        = valid_q & READY_i;
      deliver     = 1'b0;

      state_d     = state_q;
      cnt_d       = strobe ? RELOAD_FULL : cnt_q - CW'(1);
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               cnt_d   = RELOAD_HALF;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (strobe) begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_idx_d = 3'd0;
                  state_d   = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (strobe) begin
               shreg_d   = {rx_s, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (strobe) begin
               if (rx_s) begin
                  deliver = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A full holding register accepts a new byte only if it is drained this same cycle.
      if (deliver) begin
         if (!valid_q || take) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (take) begin
         valid_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign DATA_o      = data_q;
   assign VALID_o     = valid_q;
   assign FRAME_ERR_o = frame_err_q;
   assign OVERRUN_o   = overrun_q;
   assign BUSY_o      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed plus randomized bench for uart_byte_rx at default 12 MHz / 115200 baud.
`timescale 1ns/100ps
module tb_uart_byte_rx;

   localparam int DIV     = 12_000_000 / 115_200;
   localparam int LAT     = 2 + DIV / 2 + 9 * DIV + 1;
   localparam int NO_STOP = 1_000_000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, fe, ov, busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_start = 0;

   uart_byte_rx dut (
      .CLK_IN      (clk),
      .RST_IN      (rst),
      .UART_RX_i   (rx),
      .DATA_o      (data),
      .VALID_o     (valid),
      .READY_i     (ready),
      .FRAME_ERR_o (fe),
      .OVERRUN_o   (ov),
      .BUSY_o      (busy)
   );

   always #41.5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic [7:0] hs_q[$];
   int         hs_cyc[$];
   int fe_cnt = 0, ov_cnt = 0, fe_cyc = 0, ov_cyc = 0;
   int valid_rises = 0, busy_cycles = 0, long_pulses = 0;
   bit fe_prev = 0, ov_prev = 0, valid_prev = 0;

   always @(negedge clk) begin
      if (valid && ready) begin
         hs_q.push_back(data);
         hs_cyc.push_back(cyc);
      end
      if (valid && !valid_prev) valid_rises++;
      if (fe) begin
         if (fe_prev) long_pulses++;
         else begin fe_cnt++; fe_cyc = cyc; end
      end
      if (ov) begin
         if (ov_prev) long_pulses++;
         else begin ov_cnt++; ov_cyc = cyc; end
      end
      if (busy) busy_cycles++;
      fe_prev    = fe;
      ov_prev    = ov;
      valid_prev = valid;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      vectors++;
      assert (obs >= lo && obs <= hi) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Drives one 8N1 frame bit-by-bit; stops early after 'limit' cycles to emulate an aborted frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int limit);
      logic [9:0] bits;
      bits = {stop_v, b, 1'b0};
      last_start = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         for (int k = 0; k < DIV; k++) begin
            if (i * DIV + k >= limit) return;
            tick();
         end
      end
   endtask

   initial begin
      int n0, s0, s1, b0, vr0, fe0, ov0;
      logic [7:0] exp_q[$];
      logic [7:0] rb;

      // Reset state
      tick(3);
      check("rst_data",  data,  8'h00);
      check("rst_valid", valid, 1'b0);
      check("rst_busy",  busy,  1'b0);
      check("rst_fe",    fe,    1'b0);
      check("rst_ov",    ov,    1'b0);
      rst = 1'b0;
      tick(10);

      // Single byte with zero-wait consumer
      ready = 1'b1;
      n0 = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hAA, 1'b1, NO_STOP);
      s0 = last_start;
      tick(20);
      check("single_count", hs_q.size(), n0 + 1);
      if (hs_q.size() == n0 + 1) begin
         check("single_data", hs_q[n0], 8'hAA);
         check_range("single_latency", hs_cyc[n0] - s0, LAT - 1, LAT + 1);
      end
      check("single_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // Overrun: consumer stalled across two frames
      ready = 1'b0;
      n0 = hs_q.size(); ov0 = ov_cnt;
      send_frame(8'h3C, 1'b1, NO_STOP);
      send_frame(8'h55, 1'b1, NO_STOP);
      s1 = last_start;
      tick(20);
      check("ovr_valid", valid, 1'b1);
      check("ovr_data", data, 8'h3C);
      check("ovr_pulses", ov_cnt - ov0, 1);
      check_range("ovr_when", ov_cyc - s1, LAT - 1, LAT + 1);
      ready = 1'b1;
      tick(1);
      check("ovr_drain_valid", valid, 1'b0);
      check("ovr_drain_count", hs_q.size(), n0 + 1);
      if (hs_q.size() == n0 + 1) check("ovr_drain_data", hs_q[n0], 8'h3C);

      // False start: 20-cycle glitch
      tick(5);
      b0 = busy_cycles; vr0 = valid_rises; fe0 = fe_cnt;
      rx = 1'b0;
      tick(20);
      rx = 1'b1;
      tick(100);
      check_range("glitch_busy_len", busy_cycles - b0, 50, 56);
      check("glitch_no_valid", valid_rises - vr0, 0);
      check("glitch_no_fe", fe_cnt - fe0, 0);
      check("glitch_idle", busy, 1'b0);

      // Framing error followed by a long break
      vr0 = valid_rises; fe0 = fe_cnt;
      send_frame(8'h0F, 1'b0, NO_STOP);
      s0 = last_start;
      tick(3000);
      check("brk_fe_pulses", fe_cnt - fe0, 1);
      check_range("brk_fe_when", fe_cyc - s0, LAT - 1, LAT + 1);
      check("brk_no_valid", valid_rises - vr0, 0);
      check("brk_busy", busy, 1'b1);
      rx = 1'b1;
      tick(10);
      check("brk_release", busy, 1'b0);
      n0 = hs_q.size();
      send_frame(8'h81, 1'b1, NO_STOP);
      tick(20);
      check("brk_next_count", hs_q.size(), n0 + 1);
      if (hs_q.size() == n0 + 1) check("brk_next_data", hs_q[n0], 8'h81);

      // Reset during data bit 4; the sender is reset along with the receiver
      n0 = hs_q.size();
      send_frame(8'hC3, 1'b1, 5 * DIV + DIV / 2);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mid_rst_data",  data,  8'h00);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_busy",  busy,  1'b0);
      check("mid_rst_flags", {fe, ov}, 2'b00);
      tick(1200);
      check("mid_no_byte", hs_q.size(), n0);
      send_frame(8'h5A, 1'b1, NO_STOP);
      tick(20);
      check("mid_next_count", hs_q.size(), n0 + 1);
      if (hs_q.size() == n0 + 1) check("mid_next_data", hs_q[n0], 8'h5A);

      // Back-to-back stream
      n0 = hs_q.size();
      send_frame(8'h00, 1'b1, NO_STOP);
      send_frame(8'hFF, 1'b1, NO_STOP);
      send_frame(8'hA5, 1'b1, NO_STOP);
      tick(20);
      check("b2b_count", hs_q.size(), n0 + 3);
      if (hs_q.size() == n0 + 3) begin
         check("b2b_d0", hs_q[n0],     8'h00);
         check("b2b_d1", hs_q[n0 + 1], 8'hFF);
         check("b2b_d2", hs_q[n0 + 2], 8'hA5);
         check("b2b_gap1", hs_cyc[n0 + 1] - hs_cyc[n0],     10 * DIV);
         check("b2b_gap2", hs_cyc[n0 + 2] - hs_cyc[n0 + 1], 10 * DIV);
      end

      // Random bytes with random idle gaps; the model is simply the sent sequence
      n0 = hs_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom);
         exp_q.push_back(rb);
         send_frame(rb, 1'b1, NO_STOP);
         tick($urandom_range(0, 200));
      end
      tick(20);
      check("rnd_count", hs_q.size(), n0 + exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (n0 + i < hs_q.size()) check($sformatf("rnd_data%0d", i), hs_q[n0 + i], exp_q[i]);
      end
      check("rnd_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      check("pulse_widths", long_pulses, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
